// File: rtl/rob_multi.sv
// rob_multi
// Two-wide reorder buffer. ENTRIES slots form a circular queue that sits
// between decode and the register file. Tags are handed out in program
// order, results arrive on two CDB channels, and up to two completed entries
// retire per cycle, strictly in order. A flush discards everything.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   disp_en1/2, disp_reg1/2   dispatch requests and their destination regs
//   disp_ack, disp_tag1/2     all-or-nothing grant and the tags it hands out
//   cdb_en1/2, cdb_tag1/2,    result broadcasts; channel 1 wins a tag clash
//   cdb_value1/2
//   flush                     drop all entries, suppress everything this cycle
//   ret_en1/2, ret_reg1/2,    in-order retire ports (ret_en2 implies ret_en1)
//   ret_value1/2
//   rob_count, rob_full,      occupancy and status flags
//   rob_empty, rob_stall
module rob_multi #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int DATA_W  = 64,
  parameter int REG_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_en1,
  input  logic              disp_en2,
  input  logic [REG_W-1:0]  disp_reg1,
  input  logic [REG_W-1:0]  disp_reg2,
  output logic              disp_ack,
  output logic [IDX_W-1:0]  disp_tag1,
  output logic [IDX_W-1:0]  disp_tag2,
  input  logic              cdb_en1,
  input  logic              cdb_en2,
  input  logic [IDX_W-1:0]  cdb_tag1,
  input  logic [IDX_W-1:0]  cdb_tag2,
  input  logic [DATA_W-1:0] cdb_value1,
  input  logic [DATA_W-1:0] cdb_value2,
  input  logic              flush,
  output logic              ret_en1,
  output logic              ret_en2,
  output logic [REG_W-1:0]  ret_reg1,
  output logic [REG_W-1:0]  ret_reg2,
  output logic [DATA_W-1:0] ret_value1,
  output logic [DATA_W-1:0] ret_value2,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_full,
  output logic              rob_empty,
  output logic              rob_stall
);

  localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W:0] STALL_CNT = (IDX_W+1)'(ENTRIES - 2);

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] complete_q;
  logic [REG_W-1:0]   reg_q   [ENTRIES];
  logic [DATA_W-1:0]  value_q [ENTRIES];
  logic [IDX_W-1:0]   head_q;
  logic [IDX_W-1:0]   tail_q;
  logic [IDX_W:0]     count_q;

  logic [IDX_W-1:0]   head_next1;
  logic [IDX_W:0]     free_slots;
  logic [1:0]         n_req;
  logic [1:0]         n_alloc;
  logic [1:0]         n_ret;
  logic               alloc1;
  logic               alloc2;
  logic               cdb_hit1;
  logic               cdb_hit2;

  // Dispatch grant, retire selection and CDB qualification. Everything here
  // reads registered state only, so a result written on an edge shows up at
  // the retire ports one cycle later at the earliest. Space is judged on the
  // current count, so slots freed by a same-cycle retire are not reused.
  // Allocated slots are always invalid, so the valid check on the CDB tag
  // also keeps a broadcast from landing on a slot being allocated.
  always_comb begin
    n_req      = {1'b0, disp_en1} + {1'b0, disp_en2};
    free_slots = FULL_CNT - count_q;
    disp_ack   = (n_req != 2'd0) &&
                 (free_slots >= {{(IDX_W-1){1'b0}}, n_req}) && !flush;
    disp_tag1  = tail_q;
    disp_tag2  = disp_en1 ? tail_q + IDX_W'(1) : tail_q;
    n_alloc    = disp_ack ? n_req : 2'd0;
    alloc1     = disp_ack && disp_en1;
    alloc2     = disp_ack && disp_en2;

    head_next1 = head_q + IDX_W'(1);
    ret_en1    = valid_q[head_q] && complete_q[head_q] && !flush;
    ret_en2    = ret_en1 && valid_q[head_next1] && complete_q[head_next1];
    n_ret      = {1'b0, ret_en1} + {1'b0, ret_en2};
    ret_reg1   = ret_en1 ? reg_q[head_q]       : '0;
    ret_value1 = ret_en1 ? value_q[head_q]     : '0;
    ret_reg2   = ret_en2 ? reg_q[head_next1]   : '0;
    ret_value2 = ret_en2 ? value_q[head_next1] : '0;

    cdb_hit1   = cdb_en1 && valid_q[cdb_tag1] && !flush;
    cdb_hit2   = cdb_en2 && valid_q[cdb_tag2] && !flush &&
                 !(cdb_hit1 && (cdb_tag1 == cdb_tag2));

    rob_count  = count_q;
    rob_full   = (count_q == FULL_CNT);
    rob_empty  = (count_q == '0);
    rob_stall  = (count_q > STALL_CNT);
  end

  // Control state: per-slot valid/complete bits, pointers and occupancy.
  // Flush clears exactly like reset but synchronously. Retire clears come
  // after the CDB sets so a late broadcast to a retiring slot cannot revive it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      if (cdb_hit1) complete_q[cdb_tag1] <= 1'b1;
      if (cdb_hit2) complete_q[cdb_tag2] <= 1'b1;
      if (ret_en1) begin
        valid_q[head_q]    <= 1'b0;
        complete_q[head_q] <= 1'b0;
      end
      if (ret_en2) begin
        valid_q[head_next1]    <= 1'b0;
        complete_q[head_next1] <= 1'b0;
      end
      if (alloc1) begin
        valid_q[disp_tag1]    <= 1'b1;
        complete_q[disp_tag1] <= 1'b0;
      end
      if (alloc2) begin
        valid_q[disp_tag2]    <= 1'b1;
        complete_q[disp_tag2] <= 1'b0;
      end
      head_q  <= head_q + IDX_W'(n_ret);
      tail_q  <= tail_q + IDX_W'(n_alloc);
      count_q <= count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
    end
  end

  // Payload storage. It needs no reset: nothing is read out unless the slot
  // is valid and complete, and the qualifiers above already fold in flush.
  always_ff @(posedge clock) begin
    if (cdb_hit1) value_q[cdb_tag1]  <= cdb_value1;
    if (cdb_hit2) value_q[cdb_tag2]  <= cdb_value2;
    if (alloc1)   reg_q[disp_tag1]   <= disp_reg1;
    if (alloc2)   reg_q[disp_tag2]   <= disp_reg2;
  end

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi
// Self-checking bench for rob_multi. A queue of in-flight instructions
// (tag, reg, value, done) stands in for the buffer; expected port values are
// derived from that queue and the inputs currently applied. Directed
// scenarios exercise the documented corner cases, then a randomized run mixes
// dispatch, broadcasts and occasional flushes.
module tb_rob_multi;

  localparam int ENTRIES = 32;

  logic        clock;
  logic        reset;
  logic        disp_en1, disp_en2;
  logic [4:0]  disp_reg1, disp_reg2;
  logic        disp_ack;
  logic [4:0]  disp_tag1, disp_tag2;
  logic        cdb_en1, cdb_en2;
  logic [4:0]  cdb_tag1, cdb_tag2;
  logic [63:0] cdb_value1, cdb_value2;
  logic        flush;
  logic        ret_en1, ret_en2;
  logic [4:0]  ret_reg1, ret_reg2;
  logic [63:0] ret_value1, ret_value2;
  logic [5:0]  rob_count;
  logic        rob_full, rob_empty, rob_stall;

  rob_multi #(.ENTRIES(32), .IDX_W(5), .DATA_W(64), .REG_W(5)) dut (
    .clock(clock), .reset(reset),
    .disp_en1(disp_en1), .disp_en2(disp_en2),
    .disp_reg1(disp_reg1), .disp_reg2(disp_reg2),
    .disp_ack(disp_ack), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .cdb_en1(cdb_en1), .cdb_en2(cdb_en2),
    .cdb_tag1(cdb_tag1), .cdb_tag2(cdb_tag2),
    .cdb_value1(cdb_value1), .cdb_value2(cdb_value2),
    .flush(flush),
    .ret_en1(ret_en1), .ret_en2(ret_en2),
    .ret_reg1(ret_reg1), .ret_reg2(ret_reg2),
    .ret_value1(ret_value1), .ret_value2(ret_value2),
    .rob_count(rob_count), .rob_full(rob_full),
    .rob_empty(rob_empty), .rob_stall(rob_stall)
  );

  typedef struct {
    int          tag;
    logic [4:0]  rg;
    logic [63:0] val;
    bit          done;
  } ent_t;

  ent_t mq[$];
  int   next_tag;
  int   checks;
  int   failures;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelRetN();
    if (flush || mq.size() == 0 || !mq[0].done) return 0;
    if (mq.size() >= 2 && mq[1].done) return 2;
    return 1;
  endfunction

  function automatic bit modelAck();
    int n;
    n = int'(disp_en1) + int'(disp_en2);
    return (n > 0) && ((ENTRIES - mq.size()) >= n) && !flush;
  endfunction

  task automatic modelCdb(input int tag, input logic [63:0] val);
    foreach (mq[i]) begin
      if (mq[i].tag == tag) begin
        ent_t e;
        e = mq[i];
        e.val = val;
        e.done = 1'b1;
        mq[i] = e;
      end
    end
  endtask

  task automatic modelPush(input logic [4:0] rg);
    ent_t e;
    e.tag = next_tag;
    e.rg = rg;
    e.val = '0;
    e.done = 1'b0;
    mq.push_back(e);
    next_tag = (next_tag + 1) % ENTRIES;
  endtask

  task automatic applyStimulus(input logic e1, input logic [4:0] r1,
                               input logic e2, input logic [4:0] r2,
                               input logic c1, input logic [4:0] t1, input logic [63:0] v1,
                               input logic c2, input logic [4:0] t2, input logic [63:0] v2,
                               input logic fl);
    disp_en1 = e1; disp_reg1 = r1;
    disp_en2 = e2; disp_reg2 = r2;
    cdb_en1 = c1; cdb_tag1 = t1; cdb_value1 = v1;
    cdb_en2 = c2; cdb_tag2 = t2; cdb_value2 = v2;
    flush = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput();
    int n;
    int t2;
    logic [4:0]  er1, er2;
    logic [63:0] ev1, ev2;
    n = modelRetN();
    er1 = '0; er2 = '0; ev1 = '0; ev2 = '0;
    if (n >= 1) begin er1 = mq[0].rg; ev1 = mq[0].val; end
    if (n == 2) begin er2 = mq[1].rg; ev2 = mq[1].val; end
    chk("ret_en1", 64'(ret_en1), 64'(n >= 1));
    chk("ret_en2", 64'(ret_en2), 64'(n == 2));
    chk("ret_reg1", 64'(ret_reg1), 64'(er1));
    chk("ret_reg2", 64'(ret_reg2), 64'(er2));
    chk("ret_value1", ret_value1, ev1);
    chk("ret_value2", ret_value2, ev2);
    chk("rob_count", 64'(rob_count), 64'(mq.size()));
    chk("rob_full", 64'(rob_full), 64'(mq.size() == ENTRIES));
    chk("rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
    chk("rob_stall", 64'(rob_stall), 64'(mq.size() > ENTRIES - 2));
    chk("disp_ack", 64'(disp_ack), 64'(modelAck()));
    if (disp_en1 || disp_en2) begin
      t2 = disp_en1 ? (next_tag + 1) % ENTRIES : next_tag;
      chk("disp_tag1", 64'(disp_tag1), 64'(next_tag));
      chk("disp_tag2", 64'(disp_tag2), 64'(t2));
    end
  endtask

  // Advance one clock edge and update the model with the same inputs.
  task automatic tick();
    int  nr;
    bit  ack;
    nr = modelRetN();
    ack = modelAck();
    @(posedge clock);
    if (flush) begin
      mq.delete();
      next_tag = 0;
    end else begin
      if (cdb_en2) modelCdb(int'(cdb_tag2), cdb_value2);
      if (cdb_en1) modelCdb(int'(cdb_tag1), cdb_value1);
      repeat (nr) void'(mq.pop_front());
      if (ack) begin
        if (disp_en1) modelPush(disp_reg1);
        if (disp_en2) modelPush(disp_reg2);
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic        e1, e2, c1, c2, fl;
    logic [4:0]  r1, r2, t1, t2;
    logic [63:0] v1, v2;

    checks = 0;
    failures = 0;
    next_tag = 0;
    reset = 1'b1;
    idle();
    #3;
    checkOutput();
    chk("reset_ret_reg1", 64'(ret_reg1), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Basic dual dispatch, out-of-order completion, dual retire.
    applyStimulus(1, 3, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("first_tag1", 64'(disp_tag1), 64'd0);
    chk("first_tag2", 64'(disp_tag2), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 64'hBB, 0, 0, 0, 0);
    checkOutput();
    chk("count_after_dispatch", 64'(rob_count), 64'd2);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0, 64'hAA, 0, 0, 0, 0);
    checkOutput();
    tick();
    idle();
    checkOutput();
    chk("basic_ret_en2", 64'(ret_en2), 64'd1);
    chk("basic_ret_reg1", 64'(ret_reg1), 64'd3);
    chk("basic_ret_reg2", 64'(ret_reg2), 64'd7);
    chk("basic_ret_value1", ret_value1, 64'hAA);
    chk("basic_ret_value2", ret_value2, 64'hBB);
    tick();
    idle();
    checkOutput();
    chk("basic_count0", 64'(rob_count), 64'd0);

    // Fill to capacity; tail sits at 2 after the first test.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 5'($urandom), 1, 5'($urandom), 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      tick();
    end
    applyStimulus(1, 9, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("full_flag", 64'(rob_full), 64'd1);
    chk("full_no_ack", 64'(disp_ack), 64'd0);
    chk("full_tail_held", 64'(disp_tag1), 64'd2);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 2, 64'h1234, 0, 0, 0, 0);
    checkOutput();
    tick();
    idle();
    checkOutput();
    chk("single_retire", 64'(ret_en1) + 64'(ret_en2), 64'd1);
    tick();
    applyStimulus(1, 4, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("cnt31_dual_no_ack", 64'(disp_ack), 64'd0);
    tick();
    applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("cnt31_single_ack", 64'(disp_ack), 64'd1);
    chk("cnt31_single_tag", 64'(disp_tag1), 64'd2);
    tick();
    idle();
    checkOutput();
    chk("cnt31_now_full", 64'(rob_full), 64'd1);

    // Flush with a retirable head and live CDB/dispatch traffic.
    applyStimulus(0, 0, 0, 0, 1, 3, 64'h55, 0, 0, 0, 0);
    checkOutput();
    tick();
    applyStimulus(1, 8, 0, 0, 1, 4, 64'h66, 0, 0, 0, 1);
    checkOutput();
    chk("flush_ret_en1", 64'(ret_en1), 64'd0);
    chk("flush_disp_ack", 64'(disp_ack), 64'd0);
    tick();
    applyStimulus(1, 8, 0, 0, 1, 4, 64'h77, 0, 0, 0, 0);
    checkOutput();
    chk("post_flush_empty", 64'(rob_empty), 64'd1);
    chk("post_flush_tag0", 64'(disp_tag1), 64'd0);
    tick();
    idle();
    checkOutput();
    chk("stale_cdb_ignored", 64'(ret_en1), 64'd0);
    tick();

    // Drive head and tail up to 30, then straddle the wrap.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput();
    tick();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 5'(i), 1, 5'(i + 16), 0, 0, 0, 0, 0, 0, 0);
      checkOutput();
      tick();
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 5'(2 * i), 64'($urandom), 1, 5'(2 * i + 1), 64'($urandom), 0);
      checkOutput();
      tick();
    end
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      idle();
      checkOutput();
      tick();
    end
    idle();
    checkOutput();
    chk("drained_empty", 64'(rob_empty), 64'd1);
    applyStimulus(1, 10, 1, 11, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("wrap_tag30", 64'(disp_tag1), 64'd30);
    chk("wrap_tag31", 64'(disp_tag2), 64'd31);
    tick();
    applyStimulus(1, 12, 1, 13, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("wrap_tag0", 64'(disp_tag1), 64'd0);
    chk("wrap_tag1", 64'(disp_tag2), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 64'hD1, 1, 0, 64'hD0, 0);
    checkOutput();
    tick();
    applyStimulus(0, 0, 0, 0, 1, 31, 64'hC1, 1, 30, 64'hC0, 0);
    checkOutput();
    tick();
    idle();
    checkOutput();
    chk("wrap_ret_a1", 64'(ret_reg1), 64'd10);
    chk("wrap_ret_a2", 64'(ret_reg2), 64'd11);
    tick();
    idle();
    checkOutput();
    chk("wrap_ret_b1", 64'(ret_reg1), 64'd12);
    chk("wrap_ret_b2", ret_value2, 64'hD1);
    tick();

    // Asynchronous reset between edges with five entries in flight.
    applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    tick();
    applyStimulus(1, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    tick();
    applyStimulus(1, 5, 0, 0, 1, 2, 64'hE2, 0, 0, 0, 0);
    checkOutput();
    tick();
    idle();
    checkOutput();
    chk("pre_reset_ret_en1", 64'(ret_en1), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_count", 64'(rob_count), 64'd0);
    chk("async_reset_empty", 64'(rob_empty), 64'd1);
    chk("async_reset_ret_en1", 64'(ret_en1), 64'd0);
    chk("async_reset_ret_reg1", 64'(ret_reg1), 64'd0);
    mq.delete();
    next_tag = 0;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("after_reset_tag0", 64'(disp_tag1), 64'd0);
    tick();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      e1 = ($urandom_range(0, 1) == 1);
      e2 = ($urandom_range(0, 1) == 1);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      c1 = ($urandom_range(0, 9) < 7);
      c2 = ($urandom_range(0, 9) < 6);
      t1 = 5'($urandom);
      t2 = 5'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) t1 = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) t2 = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
      if ($urandom_range(0, 3) == 0) t2 = t1;
      v1 = {$urandom, $urandom};
      v2 = {$urandom, $urandom};
      fl = ($urandom_range(0, 49) == 0);
      applyStimulus(e1, r1, e2, r2, c1, t1, v1, c2, t2, v2, fl);
      checkOutput();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
